seg_monitor: RTL and testbench
==============================

SEG_MONITOR -- requirements
Module: seg_monitor

Interface
REQ-001 Parameter: STABLE_CYCLES, default 2, range 1..15; consecutive identical samples required before a pattern is accepted.
REQ-002 clk_2  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 enable  input  1  sampling enable; 0 freezes all state and outputs.
REQ-005 seg_in  input  8  observed 7-segment bus; bit0=a ... bit6=g, bit7=DP, active-high segments.
REQ-006 hex_out  output  4  last accepted decoded nibble.
REQ-007 valid  output  1  hex_out holds a legally decoded value.
REQ-008 invalid  output  1  last accepted pattern was not one of the 16 legal codes.
REQ-009 dir_up  output  1  last observed step direction; 1 = +1, 0 = -1.
REQ-010 dir_valid  output  1  dir_up meaningful (at least one legal +/-1 step seen since last resync).
REQ-011 step_err  output  1  one-cycle pulse on an accepted legal value that is neither +1 nor -1 (mod 16) from the previous one.
REQ-012 err_count  output  8  count of step errors plus invalid acceptances; saturates at 255.

Function
REQ-013 Legal codes (hex->seg_in): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71; any other value, including any value with bit7=1, is illegal.
REQ-014 Each enabled edge: seg_in captured into seg_q; run counter reset to 1 if seg_in != seg_q, else incremented, saturating at STABLE_CYCLES.
REQ-015 Acceptance occurs on the single edge where the run counter reaches STABLE_CYCLES; no re-acceptance until the run breaks.
REQ-016 Latency: seg_in changed and held before edge k -> outputs reflect it after edge k+STABLE_CYCLES-1 (STABLE_CYCLES=1: same edge).
REQ-017 FSM states: IDLE (no legal value held), FIRST (legal value held, no direction), TRACK (direction known).
REQ-018 Accept illegal, any state: invalid=1, valid=0, dir_valid=0, err_count+1, -> IDLE; hex_out holds previous value.
REQ-019 Accept legal in IDLE: hex_out=value, valid=1, invalid=0, -> FIRST.
REQ-020 Accept legal in FIRST/TRACK, value = hex_out+1 mod 16: dir_up=1, dir_valid=1, hex_out updated, -> TRACK; wrap F->0 counts as +1.
REQ-021 Accept legal in FIRST/TRACK, value = hex_out-1 mod 16: dir_up=0, dir_valid=1, hex_out updated, -> TRACK; wrap 0->F counts as -1.
REQ-022 Accept legal equal to hex_out: no output or state change, no error.
REQ-023 Accept legal, any other value: step_err pulse, err_count+1, dir_valid=0, hex_out updated, -> FIRST.
REQ-024 err_count at 255 stays 255; step_err still pulses.
REQ-025 enable=0: seg_q, run counter, FSM, outputs held; step_err forced 0.

Reset
REQ-026 reset=1 asynchronously: hex_out=0, valid=0, invalid=0, dir_up=0, dir_valid=0, step_err=0, err_count=0, seg_q=00, run counter=0, FSM=IDLE.
REQ-027 Reset mid-run discards partial runs; first post-reset acceptance requires a full fresh STABLE_CYCLES run.

Structure
REQ-028 Shared package seg_pkg holds the 16 legal segment-code constants and the FSM state enum; reused by display drivers.
REQ-029 Sub-module seg7_decode (combinational: seg_in -> nibble, legal flag) instantiated once; all registers in seg_monitor.

Verification
REQ-030 STABLE_CYCLES=2, seg_in=06 held 2 edges after reset -> hex_out=1, valid=1, dir_valid=0, state FIRST.
REQ-031 Sequence 3F,06,5B (each 2 edges) -> dir_up=1, dir_valid=1, hex_out=2; then 71,3F from F -> wrap accepted as +1, no step_err.
REQ-032 From hex_out=0 in TRACK, apply 71 then 79 -> dir_up=0 both steps, hex_out=E, err_count unchanged.
REQ-033 From hex_out=2 apply 7F (8) -> step_err one cycle, err_count=1, dir_valid=0; apply 80 -> invalid=1, valid=0, err_count=2.
REQ-034 Glitch: 06 held 2, single-cycle 5B, back to 06 -> no acceptance of 2, no error, hex_out=1; enable=0 during a run -> outputs frozen.
REQ-035 Assert reset mid-run with err_count=5 -> all outputs 0 immediately, before next clk_2 edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: legal segment codes and monitor states.
// Display drivers reuse these codes so encoder and monitor always agree.
package seg_pkg;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;
    localparam logic [7:0] SEG_A = 8'h77;
    localparam logic [7:0] SEG_B = 8'h7C;
    localparam logic [7:0] SEG_C = 8'h39;
    localparam logic [7:0] SEG_D = 8'h5E;
    localparam logic [7:0] SEG_E = 8'h79;
    localparam logic [7:0] SEG_F = 8'h71;

    localparam logic [7:0] SEG_CODES [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3,
        SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B,
        SEG_C, SEG_D, SEG_E, SEG_F
    };

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        TRACK
    } mon_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder: segment bus to nibble plus legal flag.
// Any pattern outside the 16 codes (DP set included) is flagged illegal.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [7:0] seg_in,
    output logic [3:0] nibble,
    output logic       legal
);

    // Match against the code table; nibble is 0 when nothing matches.
    always_comb begin
        nibble = 4'd0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_in == SEG_CODES[i]) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_monitor.sv
// Debounced 7-segment bus monitor: accepts stable patterns, decodes them
// and tracks up/down counting direction, flagging illegal codes and jumps.
module seg_monitor
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] seg_in,
    output logic [3:0] hex_out,
    output logic       valid,
    output logic       invalid,
    output logic       dir_up,
    output logic       dir_valid,
    output logic       step_err,
    output logic [7:0] err_count
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

    logic [7:0] seg_q;
    logic [3:0] run_q;
    logic [3:0] run_d;
    logic       accept;

    logic [3:0] dec_nib;
    logic       dec_legal;

    mon_state_t state_q;
    mon_state_t state_d;

    logic [3:0] hex_d;
    logic       valid_d;
    logic       invalid_d;
    logic       dir_up_d;
    logic       dir_valid_d;
    logic       step_err_d;
    logic       err_inc;

    logic [3:0] hex_inc;
    logic [3:0] hex_dec;

    assign hex_inc = hex_out + 4'd1;
    assign hex_dec = hex_out - 4'd1;

    seg7_decode u_decode (
        .seg_in (seg_in),
        .nibble (dec_nib),
        .legal  (dec_legal)
    );

    // Run length of identical samples; accept once when the run completes.
    always_comb begin
        run_d  = run_q;
        accept = 1'b0;
        if (enable) begin
            if (seg_in != seg_q) begin
                run_d = 4'd1;
            end else if (run_q != RUN_MAX) begin
                run_d = run_q + 4'd1;
            end
            accept = (run_d == RUN_MAX) &&
                     ((run_q != RUN_MAX) || (seg_in != seg_q));
        end
    end

    // Sample register and run counter, frozen while disabled.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            seg_q <= 8'h00;
            run_q <= 4'd0;
        end else if (enable) begin
            seg_q <= seg_in;
            run_q <= run_d;
        end
    end

    // Tracking FSM state register.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next outputs on an accepted pattern.
    always_comb begin
        state_d     = state_q;
        hex_d       = hex_out;
        valid_d     = valid;
        invalid_d   = invalid;
        dir_up_d    = dir_up;
        dir_valid_d = dir_valid;
        step_err_d  = 1'b0;
        err_inc     = 1'b0;
        if (accept) begin
            if (!dec_legal) begin
                invalid_d   = 1'b1;
                valid_d     = 1'b0;
                dir_valid_d = 1'b0;
                err_inc     = 1'b1;
                state_d     = IDLE;
            end else if (state_q == IDLE) begin
                hex_d       = dec_nib;
                valid_d     = 1'b1;
                invalid_d   = 1'b0;
                dir_valid_d = 1'b0;
                state_d     = FIRST;
            end else begin
                unique case (1'b1)
                    (dec_nib == hex_inc): begin
                        hex_d       = dec_nib;
                        dir_up_d    = 1'b1;
                        dir_valid_d = 1'b1;
                        state_d     = TRACK;
                    end
                    (dec_nib == hex_dec): begin
                        hex_d       = dec_nib;
                        dir_up_d    = 1'b0;
                        dir_valid_d = 1'b1;
                        state_d     = TRACK;
                    end
                    (dec_nib == hex_out): begin
                        state_d = state_q;
                    end
                    default: begin
                        hex_d       = dec_nib;
                        dir_valid_d = 1'b0;
                        step_err_d  = 1'b1;
                        err_inc     = 1'b1;
                        state_d     = FIRST;
                    end
                endcase
            end
        end
    end

    // Registered outputs; step_err is a single-cycle pulse.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            hex_out   <= 4'd0;
            valid     <= 1'b0;
            invalid   <= 1'b0;
            dir_up    <= 1'b0;
            dir_valid <= 1'b0;
            step_err  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            hex_out   <= hex_d;
            valid     <= valid_d;
            invalid   <= invalid_d;
            dir_up    <= dir_up_d;
            dir_valid <= dir_valid_d;
            step_err  <= step_err_d;
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg_monitor.sv
// Scoreboard bench for seg_monitor (STABLE_CYCLES=2): directed segment
// sequences push expected outputs; a monitor pops and compares them.
module tb_seg_monitor;

    typedef struct packed {
        logic [3:0] hex;
        logic       v;
        logic       inv;
        logic       up;
        logic       dv;
        logic       se;
        logic [7:0] err;
    } obs_t;

    logic       clk_2;
    logic       reset;
    logic       enable;
    logic [7:0] seg_in;
    logic [3:0] hex_out;
    logic       valid;
    logic       invalid;
    logic       dir_up;
    logic       dir_valid;
    logic       step_err;
    logic [7:0] err_count;

    int    cyc;
    int    n_tests;
    int    n_fail;
    bit    stim_done;
    obs_t  exp_q [$];
    int    cyc_q [$];
    string name_q [$];
    event  chk_ev;

    seg_monitor #(.STABLE_CYCLES(2)) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .enable    (enable),
        .seg_in    (seg_in),
        .hex_out   (hex_out),
        .valid     (valid),
        .invalid   (invalid),
        .dir_up    (dir_up),
        .dir_valid (dir_valid),
        .step_err  (step_err),
        .err_count (err_count)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc <= cyc + 1;

    function automatic obs_t mk(input logic [3:0] h, input logic v,
                                input logic i, input logic u,
                                input logic d, input logic s,
                                input logic [7:0] e);
        obs_t o;
        o.hex = h; o.v = v; o.inv = i; o.up = u;
        o.dv = d; o.se = s; o.err = e;
        return o;
    endfunction

    // Queue an expectation for the current cycle, or immediately (now=1).
    task automatic expect_obs(input string nm, input obs_t o, input bit now);
        exp_q.push_back(o);
        cyc_q.push_back(now ? -1 : cyc);
        name_q.push_back(nm);
        if (now) begin
            #1;
            ->chk_ev;
        end
    endtask

    task automatic drive(input logic [7:0] s, input int n);
        @(negedge clk_2);
        seg_in = s;
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    // Monitor: compare DUT outputs against due scoreboard entries.
    initial begin : monitor
        obs_t  act;
        obs_t  ex;
        string nm;
        int    c;
        forever begin
            @(negedge clk_2 or chk_ev);
            while (exp_q.size() > 0 &&
                   (cyc_q[0] < 0 || cyc_q[0] <= cyc)) begin
                ex = exp_q.pop_front();
                c  = cyc_q.pop_front();
                nm = name_q.pop_front();
                act = mk(hex_out, valid, invalid, dir_up,
                         dir_valid, step_err, err_count);
                n_tests++;
                if (c >= 0 && c < cyc) begin
                    n_fail++;
                    $display("FAIL %s: expectation for cycle %0d stale at %0d",
                             nm, c, cyc);
                end else if (act !== ex) begin
                    n_fail++;
                    $display("FAIL %s: got hex=%h v=%b inv=%b up=%b dv=%b se=%b err=%0d, want hex=%h v=%b inv=%b up=%b dv=%b se=%b err=%0d",
                             nm, act.hex, act.v, act.inv, act.up, act.dv,
                             act.se, act.err, ex.hex, ex.v, ex.inv, ex.up,
                             ex.dv, ex.se, ex.err);
                end
            end
        end
    end

    initial begin : stim
        int errs;
        cyc       = 0;
        n_tests   = 0;
        n_fail    = 0;
        stim_done = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        seg_in    = 8'h06;
        #2;
        expect_obs("reset_state", mk(4'h0, 0, 0, 0, 0, 0, 8'd0), 1);
        reset = 1'b0;

        drive(8'h06, 2); expect_obs("first_1", mk(4'h1, 1, 0, 0, 0, 0, 0), 0);
        drive(8'h3F, 2); expect_obs("down_0", mk(4'h0, 1, 0, 0, 1, 0, 0), 0);
        drive(8'h06, 2); expect_obs("up_1", mk(4'h1, 1, 0, 1, 1, 0, 0), 0);
        drive(8'h5B, 1); expect_obs("latency_wait", mk(4'h1, 1, 0, 1, 1, 0, 0), 0);
        drive(8'h5B, 1); expect_obs("up_2", mk(4'h2, 1, 0, 1, 1, 0, 0), 0);
        drive(8'h06, 2); expect_obs("down_1", mk(4'h1, 1, 0, 0, 1, 0, 0), 0);
        drive(8'h3F, 2); expect_obs("down_0b", mk(4'h0, 1, 0, 0, 1, 0, 0), 0);
        drive(8'h71, 2); expect_obs("wrap_down_F", mk(4'hF, 1, 0, 0, 1, 0, 0), 0);
        drive(8'h79, 2); expect_obs("down_E", mk(4'hE, 1, 0, 0, 1, 0, 0), 0);
        drive(8'h71, 2); expect_obs("up_F", mk(4'hF, 1, 0, 1, 1, 0, 0), 0);
        drive(8'h3F, 2); expect_obs("wrap_up_0", mk(4'h0, 1, 0, 1, 1, 0, 0), 0);
        drive(8'h06, 2); expect_obs("up_1b", mk(4'h1, 1, 0, 1, 1, 0, 0), 0);
        drive(8'h5B, 2); expect_obs("up_2b", mk(4'h2, 1, 0, 1, 1, 0, 0), 0);
        drive(8'h7F, 2); expect_obs("jump_8", mk(4'h8, 1, 0, 1, 0, 1, 1), 0);
        drive(8'h7F, 1); expect_obs("pulse_end", mk(4'h8, 1, 0, 1, 0, 0, 1), 0);
        drive(8'h80, 2); expect_obs("illegal_80", mk(4'h8, 0, 1, 1, 0, 0, 2), 0);
        drive(8'h06, 2); expect_obs("resync_1", mk(4'h1, 1, 0, 1, 0, 0, 2), 0);
        drive(8'h5B, 1); expect_obs("glitch", mk(4'h1, 1, 0, 1, 0, 0, 2), 0);
        drive(8'h06, 2); expect_obs("glitch_back", mk(4'h1, 1, 0, 1, 0, 0, 2), 0);

        drive(8'h3F, 1); expect_obs("run_start", mk(4'h1, 1, 0, 1, 0, 0, 2), 0);
        enable = 1'b0;
        drive(8'h3F, 3); expect_obs("frozen", mk(4'h1, 1, 0, 1, 0, 0, 2), 0);
        @(negedge clk_2);
        enable = 1'b1;
        @(posedge clk_2); #1;
        expect_obs("resume_0", mk(4'h0, 1, 0, 0, 1, 0, 2), 0);

        drive(8'h7F, 2); expect_obs("err3", mk(4'h8, 1, 0, 0, 0, 1, 3), 0);
        drive(8'h3F, 2); expect_obs("err4", mk(4'h0, 1, 0, 0, 0, 1, 4), 0);
        drive(8'h7F, 2); expect_obs("err5", mk(4'h8, 1, 0, 0, 0, 1, 5), 0);
        drive(8'h06, 1);
        #1;
        reset = 1'b1;
        expect_obs("async_reset", mk(4'h0, 0, 0, 0, 0, 0, 0), 1);
        @(negedge clk_2);
        reset = 1'b0;
        @(posedge clk_2); #1;
        expect_obs("fresh_run_wait", mk(4'h0, 0, 0, 0, 0, 0, 0), 0);
        @(posedge clk_2); #1;
        expect_obs("fresh_run_acc", mk(4'h1, 1, 0, 0, 0, 0, 0), 0);

        for (int i = 0; i < 260; i++) begin
            drive((i % 2 == 0) ? 8'h7F : 8'h3F, 2);
            errs = (i + 1 > 255) ? 255 : i + 1;
            if (i == 253 || i == 254 || i == 259) begin
                expect_obs($sformatf("sat_%0d", i),
                           mk((i % 2 == 0) ? 4'h8 : 4'h0, 1, 0, 0, 0, 1,
                              8'(errs)), 0);
            end
        end

        stim_done = 1;
        repeat (20) begin
            if (exp_q.size() != 0) @(posedge clk_2);
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
